// File: rtl/adc_lane_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : adc_lane_formatter
//  Purpose  : Formats one divclk word of ADC samples coming out of the serdes
//             deserialiser before it reaches adc_to_datamover:
//               - offset-binary -> two's complement per lane, with polarity
//                 correction for board-inverted lanes
//               - channel de-interleave for 1/2/4-channel modes
//               - ramp test pattern generator (mode 11)
//               - sticky per-lane clip flags
//             A mode change blanks out_valid long enough that no word built
//             from the old mode, or from a mix of modes, is ever marked valid.
//  Ports    : adc_divclk   in   clock (serdes divclk)
//             adc_aresetn  in   asynchronous active-low reset
//             in_valid     in   in_data valid (free-running, no backpressure)
//             in_data      in   lane i at [i*SAMPLE_W +: SAMPLE_W], offset binary
//             mode_async   in   00=1ch 01=2ch 10=4ch 11=ramp (foreign domain)
//             clip_clr     in   synchronous pulse, clears clip_flags
//             out_valid    out  out_data valid
//             out_data     out  two's complement, reordered samples
//             mode_active  out  mode currently applied
//             mode_switch  out  one-cycle pulse when mode_active changes
//             clip_flags   out  sticky clip flag per input lane
//  Revision : 1.0  initial release
// ============================================================================
module adc_lane_formatter #(
    parameter int               LANES     = 8,
    parameter int               SAMPLE_W  = 8,
    parameter logic [LANES-1:0] POL_MASK  = 8'b11111011,
    parameter int               BLANK_CYC = 4
) (
    input  logic                      adc_divclk,
    input  logic                      adc_aresetn,
    input  logic                      in_valid,
    input  logic [LANES*SAMPLE_W-1:0] in_data,
    input  logic [1:0]                mode_async,
    input  logic                      clip_clr,
    output logic                      out_valid,
    output logic [LANES*SAMPLE_W-1:0] out_data,
    output logic [1:0]                mode_active,
    output logic                      mode_switch,
    output logic [LANES-1:0]          clip_flags
);

    localparam int                c_BLANK_W   = $clog2(BLANK_CYC + 1);
    localparam logic [c_BLANK_W-1:0] c_BLANK_LOAD = c_BLANK_W'(BLANK_CYC);
    localparam logic [c_BLANK_W-1:0] c_BLANK_ONE  = c_BLANK_W'(1);
    localparam logic [SAMPLE_W-1:0]  c_RAMP_STEP  = SAMPLE_W'(LANES);
    localparam logic [SAMPLE_W-1:0]  c_POS_FULL   = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0]  c_NEG_FULL   = {1'b1, {(SAMPLE_W-1){1'b0}}};

    localparam logic [1:0] c_MODE_1CH  = 2'b00;
    localparam logic [1:0] c_MODE_2CH  = 2'b01;
    localparam logic [1:0] c_MODE_4CH  = 2'b10;
    localparam logic [1:0] c_MODE_RAMP = 2'b11;

    // Mode synchroniser and mode tracking
    logic [1:0]           r_mode_meta;
    logic [1:0]           r_mode_sync;
    logic [1:0]           r_mode_active;
    logic                 r_mode_switch;
    logic [c_BLANK_W-1:0] r_blank_cnt;

    // Ramp generator
    logic [SAMPLE_W-1:0]  r_ramp;

    // Pipeline
    logic                 r_v1;
    logic [SAMPLE_W-1:0]  r_s1 [LANES];
    logic                 r_v2;
    logic [LANES*SAMPLE_W-1:0] r_s2;
    logic [LANES-1:0]     r_clip;

    // Combinational lane views
    logic [SAMPLE_W-1:0]  w_conv      [LANES];
    logic [SAMPLE_W-1:0]  w_ramp_word [LANES];
    logic [SAMPLE_W-1:0]  w_reord     [LANES];
    logic [LANES-1:0]     w_clip_hit;
    logic [LANES*SAMPLE_W-1:0] w_reord_flat;

    logic w_in_ramp;
    logic w_mode_change;
    assign w_in_ramp     = (r_mode_active == c_MODE_RAMP);
    assign w_mode_change = (r_mode_sync != r_mode_active);

    // Per-lane conversion. Flipping the MSB turns offset binary into two's
    // complement; an inverted lane additionally needs negation, which for
    // the biased code reduces to keeping the MSB and inverting the rest.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SAMPLE_W-1:0] w_raw;
            assign w_raw = in_data[gi*SAMPLE_W +: SAMPLE_W];

            if (POL_MASK[gi]) begin : g_inv
                assign w_conv[gi] = {w_raw[SAMPLE_W-1], ~w_raw[SAMPLE_W-2:0]};
            end else begin : g_norm
                assign w_conv[gi] = {~w_raw[SAMPLE_W-1], w_raw[SAMPLE_W-2:0]};
            end

            assign w_clip_hit[gi]  = (w_conv[gi] == c_POS_FULL) || (w_conv[gi] == c_NEG_FULL);
            assign w_ramp_word[gi] = r_ramp + SAMPLE_W'(gi);
        end
    endgenerate

    // De-interleave: with C channels, output sample j = g*(LANES/C)+t is taken
    // from lane t*C+g, so each channel ends up in a contiguous block.
    genvar gj;
    generate
        for (gj = 0; gj < LANES; gj++) begin : g_out
            localparam int c_IDX2 = (gj % (LANES/2)) * 2 + gj / (LANES/2);
            localparam int c_IDX4 = (gj % (LANES/4)) * 4 + gj / (LANES/4);

            assign w_reord[gj] = (r_mode_active == c_MODE_2CH) ? r_s1[c_IDX2] :
                                 (r_mode_active == c_MODE_4CH) ? r_s1[c_IDX4] :
                                                                 r_s1[gj];
            assign w_reord_flat[gj*SAMPLE_W +: SAMPLE_W] = w_reord[gj];
        end
    endgenerate

    always_ff @(posedge adc_divclk or negedge adc_aresetn) begin
        if (!adc_aresetn) begin
            r_mode_meta   <= c_MODE_1CH;
            r_mode_sync   <= c_MODE_1CH;
            r_mode_active <= c_MODE_1CH;
            r_mode_switch <= 1'b0;
            r_blank_cnt   <= c_BLANK_LOAD;
            r_ramp        <= '0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_s2          <= '0;
            r_clip        <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1[i] <= '0;
            end
        end else begin
            r_mode_meta <= mode_async;
            r_mode_sync <= r_mode_meta;

            // A mode change (re)loads the blanking window, so a second change
            // arriving while blanked extends it from that point.
            if (w_mode_change) begin
                r_mode_active <= r_mode_sync;
                r_mode_switch <= 1'b1;
                r_blank_cnt   <= c_BLANK_LOAD;
            end else begin
                r_mode_switch <= 1'b0;
                if (r_blank_cnt != '0) begin
                    r_blank_cnt <= r_blank_cnt - c_BLANK_ONE;
                end
            end

            if (w_mode_change && (r_mode_sync == c_MODE_RAMP)) begin
                r_ramp <= '0;
            end else if (w_in_ramp) begin
                r_ramp <= r_ramp + c_RAMP_STEP;
            end

            // Stage 1
            if (w_in_ramp) begin
                r_v1 <= 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    r_s1[i] <= w_ramp_word[i];
                end
            end else begin
                r_v1 <= in_valid;
                for (int i = 0; i < LANES; i++) begin
                    r_s1[i] <= w_conv[i];
                end
            end

            // New clips take priority over a simultaneous clear
            r_clip <= (r_clip & ~{LANES{clip_clr}}) |
                      ((in_valid && !w_in_ramp) ? w_clip_hit : '0);

            // Stage 2
            r_v2 <= r_v1;
            r_s2 <= w_reord_flat;
        end
    end

    assign out_valid   = r_v2 && (r_blank_cnt == '0);
    assign out_data    = r_s2;
    assign mode_active = r_mode_active;
    assign mode_switch = r_mode_switch;
    assign clip_flags  = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_adc_lane_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_lane_formatter
//  Purpose  : Self-checking bench for adc_lane_formatter with default
//             parameters (8 lanes x 8 bits, POL_MASK 8'b11111011, 4 blank
//             cycles). Table of steady-state vectors plus directed sequences
//             for reset, mode switching, ramp, clip flags and mid-stream reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_lane_formatter;

    localparam int DW = 64;

    logic          adc_divclk  = 1'b0;
    logic          adc_aresetn = 1'b0;
    logic          in_valid    = 1'b0;
    logic [DW-1:0] in_data     = '0;
    logic [1:0]    mode_async  = 2'b00;
    logic          clip_clr    = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    mode_active;
    logic          mode_switch;
    logic [7:0]    clip_flags;

    int n_checks = 0;
    int n_errors = 0;

    // Raw words: lane i converts to value i; and a generic pattern
    localparam logic [DW-1:0] c_RAW_IDX = 64'h78797A7B7C827E7F;
    localparam logic [DW-1:0] c_RAW_GEN = 64'h0123456789ABCDEF;

    adc_lane_formatter dut (
        .adc_divclk  (adc_divclk),
        .adc_aresetn (adc_aresetn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .mode_async  (mode_async),
        .clip_clr    (clip_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .mode_active (mode_active),
        .mode_switch (mode_switch),
        .clip_flags  (clip_flags)
    );

    always #5 adc_divclk = ~adc_divclk;

    typedef struct {
        logic [1:0]    mode;
        logic          vin;
        logic [DW-1:0] din;
        logic          vexp;
        logic [DW-1:0] dexp;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge adc_divclk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ticks until mode_switch is seen (bounded); returns cycles taken, 0 if never
    task automatic wait_switch(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mode_switch) begin
                cyc = i;
                break;
            end
        end
        check("mode_switch_latency", cyc, 3);
    endtask

    // Release reset just after an edge and confirm the blanked start-up
    task automatic release_and_check_drop(input string tag);
        adc_aresetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check({tag, "_startup_valid"}, out_valid, (k == 4) ? 1 : 0);
        end
        check({tag, "_startup_data"}, out_data, 64'h0706050403020100);
    endtask

    initial begin
        int            cyc;
        int            low_cnt;
        logic [DW-1:0] e;

        vecs[0] = '{2'b00, 1'b1, 64'h8080808080808080, 1'b1, 64'hFFFFFFFFFF00FFFF};
        vecs[1] = '{2'b00, 1'b1, 64'h0000000000000000, 1'b1, 64'h7F7F7F7F7F807F7F};
        vecs[2] = '{2'b00, 1'b1, c_RAW_GEN,            1'b1, 64'h7E5C3A18F62BB290};
        vecs[3] = '{2'b00, 1'b1, c_RAW_IDX,            1'b1, 64'h0706050403020100};
        vecs[4] = '{2'b00, 1'b0, c_RAW_IDX,            1'b0, 64'h0706050403020100};
        vecs[5] = '{2'b10, 1'b1, c_RAW_IDX,            1'b1, 64'h0703060205010400};
        vecs[6] = '{2'b10, 1'b1, c_RAW_GEN,            1'b1, 64'h7EF65C2B3AB21890};
        vecs[7] = '{2'b01, 1'b1, c_RAW_IDX,            1'b1, 64'h0705030106040200};
        vecs[8] = '{2'b01, 1'b1, c_RAW_GEN,            1'b1, 64'h7E3AF6B25C182B90};
        vecs[9] = '{2'b01, 1'b0, c_RAW_IDX,            1'b0, 64'h0705030106040200};

        // ---------------- reset state ----------------
        in_valid = 1'b1;
        in_data  = c_RAW_IDX;
        repeat (3) tick();
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_data",    out_data,    0);
        check("rst_mode_active", mode_active, 0);
        check("rst_mode_switch", mode_switch, 0);
        check("rst_clip_flags",  clip_flags,  0);
        release_and_check_drop("rst");

        // ---------------- table vectors ----------------
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].mode != mode_async) begin
                mode_async = vecs[v].mode;
                repeat (12) tick();
            end
            in_valid = vecs[v].vin;
            in_data  = vecs[v].din;
            tick();
            tick();
            check($sformatf("vec%0d_data", v),  out_data,  vecs[v].dexp);
            check($sformatf("vec%0d_valid", v), out_valid, vecs[v].vexp);
        end

        // ---------------- mode switch 00 -> 01 ----------------
        in_valid   = 1'b1;
        in_data    = c_RAW_IDX;
        mode_async = 2'b00;
        repeat (12) tick();
        check("pre_switch_data", out_data, 64'h0706050403020100);
        mode_async = 2'b01;
        wait_switch(cyc);
        check("sw1_mode_active", mode_active, 2'b01);
        check("sw1_valid_t0",    out_valid,   0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("sw1_valid_t%0d", k), out_valid, 0);
            if (k == 1) check("sw1_pulse_width", mode_switch, 0);
        end
        tick();
        check("sw1_valid_t4", out_valid, 1);
        check("sw1_data_2ch", out_data,  64'h0705030106040200);

        // ---------------- second change during blanking restarts it ----------------
        mode_async = 2'b10;
        wait_switch(cyc);
        mode_async = 2'b00;
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            low_cnt++;
            tick();
        end
        check("sw2_blank_len",    low_cnt,     7);
        check("sw2_mode_active",  mode_active, 2'b00);
        check("sw2_data_1ch",     out_data,    64'h0706050403020100);

        // ---------------- ramp mode ----------------
        in_valid   = 1'b0;
        in_data    = '0;
        mode_async = 2'b11;
        wait_switch(cyc);
        check("ramp_mode_active", mode_active, 2'b11);
        tick();
        tick();
        for (int k = 0; k < 34; k++) begin
            for (int j = 0; j < 8; j++) begin
                e[j*8 +: 8] = 8'(k*8 + j);
            end
            check($sformatf("ramp%0d_data", k),  out_data,  e);
            check($sformatf("ramp%0d_valid", k), out_valid, (k >= 2) ? 1 : 0);
            tick();
        end

        // ---------------- clip flags ----------------
        mode_async = 2'b00;
        repeat (12) tick();
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        check("clip_cleared", clip_flags, 8'h00);
        in_data  = 64'h78797A7B00827E7F;   // lane 3 converts to 0x7F
        in_valid = 1'b0;
        tick();
        check("clip_needs_valid", clip_flags, 8'h00);
        in_valid = 1'b1;
        tick();
        check("clip_lane3_set", clip_flags, 8'h08);
        in_valid = 1'b0;
        repeat (3) tick();
        check("clip_lane3_sticky", clip_flags, 8'h08);
        in_valid = 1'b1;
        clip_clr = 1'b1;
        tick();
        check("clip_set_wins", clip_flags, 8'h08);
        in_valid = 1'b0;
        tick();
        clip_clr = 1'b0;
        check("clip_clr_alone", clip_flags, 8'h00);
        in_data  = 64'h78797A7B7C007E7F;   // lane 2 converts to 0x80
        in_valid = 1'b1;
        tick();
        check("clip_lane2_neg", clip_flags, 8'h04);

        // ---------------- reset mid-stream ----------------
        in_data    = c_RAW_IDX;
        mode_async = 2'b10;
        repeat (12) tick();
        check("mid_pre_valid", out_valid,   1);
        check("mid_pre_mode",  mode_active, 2'b10);
        #2;
        adc_aresetn = 1'b0;
        mode_async  = 2'b00;
        #1;
        check("mid_async_valid", out_valid,   0);
        check("mid_async_mode",  mode_active, 0);
        check("mid_async_data",  out_data,    0);
        check("mid_async_clip",  clip_flags,  0);
        tick();
        release_and_check_drop("mid");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
